onehot_decoder_pipe: RTL and testbench
======================================

// Module: onehot_decoder_pipe
// PURPOSE
//  Registered binary-to-one-hot decoder with valid/ready handshake on both sides.
//  - Inverse of the 8:3 encoders: takes a binary code, emits a one-hot word.
//  - Sits between a code producer (e.g. a priority-encoded request index) and a
//    one-hot consumer (e.g. grant/select lines).
//  - Includes a 2-entry skid buffer, so in_ready is registered and full throughput
//    is held under back-pressure.
// PARAMETERS
//  CODE_W   3  width of binary input code
//  NUM_OUT  8  one-hot output width; must satisfy 2 <= NUM_OUT <= 2**CODE_W
//  ERR_CW   8  width of the saturating invalid-code counter
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        input code valid
//  in_ready   out  1        decoder can accept a code this cycle
//  in_code    in   CODE_W   binary code to decode
//  out_valid  out  1        out_onehot holds a decoded word
//  out_ready  in   1        consumer accepts the word this cycle
//  out_onehot out  NUM_OUT  decoded word; bit[in_code] set, or all zero if invalid
//  out_err    out  1        word is from an invalid code (in_code >= NUM_OUT)
//  err_count  out  ERR_CW   count of invalid codes accepted; saturates at all-ones
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge) forces:
//    in_ready=0 during reset, then 1 on the first cycle after reset deasserts;
//    out_valid=0, out_onehot=0, out_err=0, err_count=0; both skid entries empty.
//  - Reset mid-transfer drops all buffered words with no output.
//  - Input handshake: a transfer occurs when in_valid && in_ready at a clk edge.
//  - Output handshake: a transfer occurs when out_valid && out_ready at a clk edge.
//  - Decode: bit i of the word = (in_code == i) for i < NUM_OUT.
//    Decode happens at accept and is stored with the word.
//  - Invalid code (in_code >= NUM_OUT): word = 0, out_err=1 travels with it.
//    err_count increments on accept; it holds at 2**ERR_CW-1 and does not wrap.
//  - Buffer: 2 entries, main (drives the outputs) and skid.
//    Accept into main when main is empty or being popped this cycle; else into skid.
//    On a pop with skid occupied, skid moves to main the same edge.
//  - Latency: 1 cycle from accept to out_valid when main is empty.
//    Back-to-back accept and pop each cycle gives 1 word/cycle.
//  - in_ready = !skid_full, registered (no combinational path from out_ready).
//  - out_valid and out_onehot are stable while out_valid && !out_ready (AXI-style hold).
//  - in_code is ignored when in_valid=0.
//  - Simultaneous push and pop with both entries full cannot occur (in_ready=0).
//  - out_onehot is always one-hot or zero; it never has two bits set.
// CONFIGURATION
//  Macro ONEHOT_DEC_THERMO_EN:
//  - Defined: adds output port out_thermo [NUM_OUT-1:0], registered with the word.
//    Bits [code:0] are set (thermometer code); all zero for an invalid code.
//    Reset value is 0.
//  - Undefined: the port and its logic are absent; all other behaviour is identical.
// TESTING
//  T1 reset: hold rst 3 cycles with in_valid=1 ->
//     out_valid=0, err_count=0; in_ready=1 one cycle after release.
//  T2 sweep: out_ready=1, codes 0..7 on back-to-back cycles ->
//     out_onehot 8'h01,02,04,...,80 on consecutive cycles, each 1 cycle after accept.
//  T3 back-pressure: send codes 2,5,6 with out_ready=0 ->
//     in_ready=0 after 2 accepts; out_onehot holds 8'h04.
//     Release out_ready -> 8'h04, then 8'h20, then 8'h40 (code 6 accepted once
//     in_ready returns). No loss, no duplicates.
//  T4 invalid: NUM_OUT=5, send code 6 ->
//     out_onehot=0, out_err=1, err_count=1.
//     With ERR_CW=2 and 5 invalid codes, err_count stays at 3.
//  T5 mid-reset: fill both entries, assert rst for 1 cycle ->
//     out_valid=0 the next cycle; the buffered words never appear.
//  T6 thermo (with ONEHOT_DEC_THERMO_EN defined): code 3 ->
//     out_thermo=8'h0F, out_onehot=8'h08.

Source files
------------

// File: rtl/onehot_decoder_pipe.sv
// Registered binary-to-one-hot decoder with a 2-entry skid buffer on a valid/ready pipe.
// Optional thermometer output enabled by defining ONEHOT_DEC_THERMO_EN.
module onehot_decoder_pipe #(
  parameter int CODE_W  = 3,
  parameter int NUM_OUT = 8,
  parameter int ERR_CW  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CODE_W-1:0]  in_code,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] out_onehot,
  output logic               out_err,
  output logic [ERR_CW-1:0]  err_count
`ifdef ONEHOT_DEC_THERMO_EN
  ,
  output logic [NUM_OUT-1:0] out_thermo
`endif
);

  // Both sides: a word moves on a clk edge where valid && ready; a producer holds
  // valid and data stable until that edge, and ready never depends on valid.

  logic               accept;
  logic               pop;

  logic [NUM_OUT-1:0] dec_onehot;
  logic               dec_err;

  logic               main_valid_q, main_valid_d;
  logic [NUM_OUT-1:0] main_onehot_q, main_onehot_d;
  logic               main_err_q, main_err_d;

  logic               skid_valid_q, skid_valid_d;
  logic [NUM_OUT-1:0] skid_onehot_q, skid_onehot_d;
  logic               skid_err_q, skid_err_d;

  logic               in_ready_q, in_ready_d;
  logic [ERR_CW-1:0]  err_count_q, err_count_d;

`ifdef ONEHOT_DEC_THERMO_EN
  logic [NUM_OUT-1:0] dec_thermo;
  logic [NUM_OUT-1:0] main_thermo_q, main_thermo_d;
  logic [NUM_OUT-1:0] skid_thermo_q, skid_thermo_d;
`endif

  assign accept = in_valid && in_ready_q;
  assign pop    = main_valid_q && out_ready;

  // Decode once at accept; the stored word never changes afterwards.
  always_comb begin
    dec_onehot = '0;
    dec_err    = (int'(in_code) >= NUM_OUT);
    for (int i = 0; i < NUM_OUT; i++) begin
      dec_onehot[i] = (int'(in_code) == i);
    end
  end

`ifdef ONEHOT_DEC_THERMO_EN
  always_comb begin
    dec_thermo = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      dec_thermo[i] = !dec_err && (i <= int'(in_code));
    end
  end
`endif

  always_comb begin
    main_valid_d  = main_valid_q;
    main_onehot_d = main_onehot_q;
    main_err_d    = main_err_q;
    skid_valid_d  = skid_valid_q;
    skid_onehot_d = skid_onehot_q;
    skid_err_d    = skid_err_q;
`ifdef ONEHOT_DEC_THERMO_EN
    main_thermo_d = main_thermo_q;
    skid_thermo_d = skid_thermo_q;
`endif

    // Pop first: skid refills main, otherwise main empties.
    if (pop) begin
      if (skid_valid_q) begin
        main_onehot_d = skid_onehot_q;
        main_err_d    = skid_err_q;
`ifdef ONEHOT_DEC_THERMO_EN
        main_thermo_d = skid_thermo_q;
`endif
        skid_valid_d  = 1'b0;
      end else begin
        main_valid_d  = 1'b0;
      end
    end

    // The new word lands in main if the pop left it empty, else in skid.
    if (accept) begin
      if (!main_valid_d) begin
        main_valid_d  = 1'b1;
        main_onehot_d = dec_onehot;
        main_err_d    = dec_err;
`ifdef ONEHOT_DEC_THERMO_EN
        main_thermo_d = dec_thermo;
`endif
      end else begin
        skid_valid_d  = 1'b1;
        skid_onehot_d = dec_onehot;
        skid_err_d    = dec_err;
`ifdef ONEHOT_DEC_THERMO_EN
        skid_thermo_d = dec_thermo;
`endif
      end
    end

    in_ready_d = !skid_valid_d;

    err_count_d = err_count_q;
    if (accept && dec_err && (err_count_q != {ERR_CW{1'b1}})) begin
      err_count_d = err_count_q + ERR_CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q  <= 1'b0;
      main_onehot_q <= '0;
      main_err_q    <= 1'b0;
      skid_valid_q  <= 1'b0;
      skid_onehot_q <= '0;
      skid_err_q    <= 1'b0;
      in_ready_q    <= 1'b0;
      err_count_q   <= '0;
`ifdef ONEHOT_DEC_THERMO_EN
      main_thermo_q <= '0;
      skid_thermo_q <= '0;
`endif
    end else begin
      main_valid_q  <= main_valid_d;
      main_onehot_q <= main_onehot_d;
      main_err_q    <= main_err_d;
      skid_valid_q  <= skid_valid_d;
      skid_onehot_q <= skid_onehot_d;
      skid_err_q    <= skid_err_d;
      in_ready_q    <= in_ready_d;
      err_count_q   <= err_count_d;
`ifdef ONEHOT_DEC_THERMO_EN
      main_thermo_q <= main_thermo_d;
      skid_thermo_q <= skid_thermo_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = main_valid_q;
  assign out_onehot = main_onehot_q;
  assign out_err    = main_err_q;
  assign err_count  = err_count_q;
`ifdef ONEHOT_DEC_THERMO_EN
  assign out_thermo = main_thermo_q;
`endif

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Bench for onehot_decoder_pipe: default 8-output instance on a scoreboard, plus a
// 5-output / 2-bit-counter instance for invalid-code and saturation behaviour.
module tb_onehot_decoder_pipe;

  localparam int CODE_W    = 3;
  localparam int NUM_OUT   = 8;
  localparam int ERR_CW    = 8;
  localparam int B_NUM_OUT = 5;
  localparam int B_ERR_CW  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               in_valid  = 1'b1;
  logic               in_ready;
  logic [CODE_W-1:0]  in_code   = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [NUM_OUT-1:0] out_onehot;
  logic               out_err;
  logic [ERR_CW-1:0]  err_count;

  logic                 b_in_valid  = 1'b1;
  logic                 b_in_ready;
  logic [CODE_W-1:0]    b_in_code   = '0;
  logic                 b_out_valid;
  logic                 b_out_ready = 1'b0;
  logic [B_NUM_OUT-1:0] b_out_onehot;
  logic                 b_out_err;
  logic [B_ERR_CW-1:0]  b_err_count;

`ifdef ONEHOT_DEC_THERMO_EN
  logic [NUM_OUT-1:0]   out_thermo;
  logic [B_NUM_OUT-1:0] b_out_thermo;
`endif

  onehot_decoder_pipe #(.CODE_W(CODE_W), .NUM_OUT(NUM_OUT), .ERR_CW(ERR_CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .out_err    (out_err),
    .err_count  (err_count)
`ifdef ONEHOT_DEC_THERMO_EN
    ,
    .out_thermo (out_thermo)
`endif
  );

  onehot_decoder_pipe #(.CODE_W(CODE_W), .NUM_OUT(B_NUM_OUT), .ERR_CW(B_ERR_CW)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .in_code    (b_in_code),
    .out_valid  (b_out_valid),
    .out_ready  (b_out_ready),
    .out_onehot (b_out_onehot),
    .out_err    (b_out_err),
    .err_count  (b_err_count)
`ifdef ONEHOT_DEC_THERMO_EN
    ,
    .out_thermo (b_out_thermo)
`endif
  );

  // ---------------- scoreboard state ----------------
  // entry layout: [16:9] thermo, [8] err, [7:0] onehot
  logic [16:0] exp_q[$];
  int          n_checks  = 0;
  int          n_fail    = 0;
  int          occ       = 0;
  logic        exp_ready = 1'b1;
  int          b_err_exp = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] model8(input int code);
    logic [7:0] oh;
    logic [7:0] th;
    oh = 8'(1 << code);
    th = 8'((1 << (code + 1)) - 1);
    return {th, 1'b0, oh};
  endfunction

  // ---------------- driver tasks ----------------
  // One cycle on the main instance: drive at negedge, check, account for the next edge.
  task automatic cycle(input logic v, input logic [CODE_W-1:0] code, input logic ordy,
                       output logic accepted);
    logic        push;
    logic        pop;
    logic [16:0] e;
    @(negedge clk);
    in_valid  = v;
    in_code   = code;
    out_ready = ordy;
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("out_valid", 32'(out_valid), 32'(occ != 0));
    chk("err_count", 32'(err_count), 32'd0);
    chk("onehot_or_zero", 32'($countones(out_onehot) <= 1), 32'd1);
    push = v && in_ready;
    pop  = out_valid && ordy;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 32'(out_onehot), 32'hdead);
      end else begin
        e = exp_q[0];
        chk("onehot", 32'(out_onehot), 32'(e[7:0]));
        chk("err", 32'(out_err), 32'(e[8]));
`ifdef ONEHOT_DEC_THERMO_EN
        chk("thermo", 32'(out_thermo), 32'(e[16:9]));
`endif
        if (pop) void'(exp_q.pop_front());
      end
    end
    if (push) exp_q.push_back(model8(int'(code)));
    occ       = occ + int'(push) - int'(pop);
    exp_ready = (occ < 2);
    accepted  = push;
  endtask

  task automatic drain();
    logic acc;
    int   guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      cycle(1'b0, '0, 1'b1, acc);
      guard++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst        = 1'b1;
    in_valid   = 1'b1;
    b_in_valid = 1'b1;
    in_code    = 3'($urandom_range(0, 7));
    repeat (n) begin
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      chk("rst_b_err_count", 32'(b_err_count), 32'd0);
      chk("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    end
    rst        = 1'b0;
    in_valid   = 1'b0;
    b_in_valid = 1'b0;
    exp_q.delete();
    occ        = 0;
    exp_ready  = 1'b1;
    b_err_exp  = 0;
  endtask

  // One word through the 5-output instance with the consumer always ready.
  task automatic b_send(input logic [CODE_W-1:0] code);
    logic [B_NUM_OUT-1:0] eo;
    logic [B_NUM_OUT-1:0] et;
    logic                 ee;
    ee = (int'(code) >= B_NUM_OUT);
    eo = ee ? '0 : B_NUM_OUT'(1 << code);
    et = ee ? '0 : B_NUM_OUT'((1 << (int'(code) + 1)) - 1);
    @(negedge clk);
    chk("b_in_ready", 32'(b_in_ready), 32'd1);
    b_in_valid  = 1'b1;
    b_in_code   = code;
    b_out_ready = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    if (ee && b_err_exp < 3) b_err_exp++;
    chk("b_out_valid", 32'(b_out_valid), 32'd1);
    chk("b_onehot", 32'(b_out_onehot), 32'(eo));
    chk("b_err", 32'(b_out_err), 32'(ee));
    chk("b_err_count", 32'(b_err_count), 32'(b_err_exp));
`ifdef ONEHOT_DEC_THERMO_EN
    chk("b_thermo", 32'(b_out_thermo), 32'(et));
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic acc;

    // T1: reset held 3 cycles with in_valid high
    do_reset(3);
    @(negedge clk);
    chk("t1_in_ready_after_release", 32'(in_ready), 32'd1);
    chk("t1_out_valid", 32'(out_valid), 32'd0);
    exp_ready = 1'b1;

    // T2: sweep all codes back to back
    for (int i = 0; i < NUM_OUT; i++) begin
      cycle(1'b1, 3'(i), 1'b1, acc);
      chk("t2_accept", 32'(acc), 32'd1);
    end
    drain();

    // T3: back-pressure fills both entries
    cycle(1'b1, 3'd2, 1'b0, acc);
    cycle(1'b1, 3'd5, 1'b0, acc);
    cycle(1'b1, 3'd6, 1'b0, acc);
    chk("t3_blocked", 32'(acc), 32'd0);
    cycle(1'b1, 3'd6, 1'b0, acc);
    chk("t3_blocked2", 32'(acc), 32'd0);
    chk("t3_hold", 32'(out_onehot), 32'h04);
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) cycle(1'b1, 3'd6, 1'b1, acc);
    chk("t3_accept6", 32'(acc), 32'd1);
    drain();

    // T4: invalid codes and counter saturation on the 5-output instance
    in_valid  = 1'b0;
    out_ready = 1'b1;
    b_send(3'd6);
    chk("t4_err_count_one", 32'(b_err_count), 32'd1);
    b_send(3'd4);
    b_send(3'd0);
    b_send(3'd5);
    b_send(3'd7);
    b_send(3'd6);
    b_send(3'd5);
    b_send(3'd6);
    chk("t4_err_count_sat", 32'(b_err_count), 32'd3);

    // random traffic with random back-pressure
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 3) != 0), acc);
    end
    drain();

    // T5: reset with both entries full drops the buffered words
    cycle(1'b1, 3'd1, 1'b0, acc);
    cycle(1'b1, 3'd3, 1'b0, acc);
    chk("t5_full", 32'(occ), 32'd2);
    do_reset(1);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, acc);
    chk("t5_no_output", 32'(out_valid), 32'd0);

    // T6: code 3 (thermometer checked through the scoreboard when enabled)
    cycle(1'b1, 3'd3, 1'b1, acc);
    cycle(1'b0, '0, 1'b1, acc);
    for (int i = 0; i < 100; i++) begin
      cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), acc);
    end
    drain();

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
